float_point_addsub_pipe: RTL and testbench

FLOAT_POINT_ADDSUB_PIPE -- requirements
Module: float_point_addsub_pipe

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_lzc.sv | 19 +
 rtl/float_point_addsub_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_float_point_addsub_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point constants, op encodings and flag indices
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Quiet NaN: sign 0, exponent all-ones, fraction MSB set. Callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Positive infinity; OR in the sign bit for -inf.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - parametrised leading-zero counter
// Ports: din (W bits), cnt = number of zeros above the highest set bit (W when din is zero).
module fp_lzc #(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit is the last to win.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/float_point_addsub_pipe.sv
// rtl/float_point_addsub_pipe.sv - four-stage pipelined floating-point adder/subtractor
// Ports: clk, reset (sync, active-high); iA/iB/iOp/iValid in with oAccept;
//        oF/oFlags/oDone out with iReady. oFlags = {invalid, overflow, underflow, inexact}.
module float_point_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXP_W+MAN_W:0] iA,
    input  logic [EXP_W+MAN_W:0] iB,
    input  logic [1:0]           iOp,
    input  logic                 iValid,
    output logic                 oAccept,
    input  logic                 iReady,
    output logic [EXP_W+MAN_W:0] oF,
    output logic                 oDone,
    output logic [3:0]           oFlags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int NW     = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW     = MAN_W + 5;          // NW plus carry-out
    localparam int CW     = $clog2(SW + 1);
    localparam int EMAX_I = (1 << EXP_W) - 1;
    localparam logic [W-1:0]     QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]     PINF = W'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-1:0]     SIGN = {1'b1, {(W-1){1'b0}}};
    localparam logic [EXP_W-1:0] EMAX = '1;

    // Global stall: nothing moves while a finished result waits for downstream.
    logic adv;
    assign adv     = !(oDone && !iReady);
    assign oAccept = adv;

    // ---------------- S1: unpack, classify, swap so |X| >= |Y| ----------------
    logic               sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, op_ok;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic [MAN_W:0]     ma, mb;
    logic [W-2:0]       ka, kb;
    logic               sp_n;
    logic [W-1:0]       spr_n;
    logic [3:0]         spf_n;

    always_comb begin
        sa     = iA[W-1];
        sb     = iB[W-1] ^ (iOp == OP_SUB);     // subtract is add with B's sign flipped
        ea     = iA[W-2:MAN_W];
        eb     = iB[W-2:MAN_W];
        fa     = iA[MAN_W-1:0];
        fb     = iB[MAN_W-1:0];
        op_ok  = (iOp == OP_ADD) || (iOp == OP_SUB);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EMAX) && (fa == '0);
        b_inf  = (eb == EMAX) && (fb == '0);
        a_nan  = (ea == EMAX) && (fa != '0);
        b_nan  = (eb == EMAX) && (fb != '0);
        // Denormals are flushed: zero exponent means zero significand.
        ma     = {!a_zero, fa & {MAN_W{!a_zero}}};
        mb     = {!b_zero, fb & {MAN_W{!b_zero}}};
        ka     = {ea, fa & {MAN_W{!a_zero}}};
        kb     = {eb, fb & {MAN_W{!b_zero}}};
        swap   = kb > ka;

        sp_n  = 1'b1;
        spr_n = '0;
        spf_n = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spr_n          = QNAN;
            spf_n[FLAG_NV] = 1'b1;
        end else if (a_inf) begin
            spr_n = PINF | (sa ? SIGN : '0);
        end else if (b_inf) begin
            spr_n = PINF | (sb ? SIGN : '0);
        end else if (a_zero && b_zero) begin
            spr_n = (sa && sb) ? SIGN : '0;     // only (-0)+(-0) keeps the minus sign
        end else begin
            sp_n = 1'b0;
        end
    end

    logic               v1, sp1, sx1, sub1;
    logic [W-1:0]       spr1;
    logic [3:0]         spf1;
    logic [EXP_W-1:0]   ex1, ey1;
    logic [MAN_W:0]     mx1, my1;

    // ---------------- S2: align Y, folding shifted-out bits into sticky ----------------
    logic [31:0]        diff;
    logic [NW-1:0]      y_ext, y_sh, y_mask, y_al;

    always_comb begin
        diff   = 32'(ex1) - 32'(ey1);
        y_ext  = {my1, 3'b000};
        y_sh   = '0;
        y_mask = '0;
        if (diff > 32'(MAN_W + 3)) begin
            y_al = {{(NW-1){1'b0}}, |my1};
        end else begin
            y_mask = ~({NW{1'b1}} << diff);
            y_sh   = y_ext >> diff;
            y_al   = {y_sh[NW-1:1], y_sh[0] | (|(y_ext & y_mask))};
        end
    end

    logic               v2, sp2, s2, sub2;
    logic [W-1:0]       spr2;
    logic [3:0]         spf2;
    logic [EXP_W-1:0]   e2;
    logic [NW-1:0]      xs2, ys2;

    // ---------------- S3: effective add/sub (never negative since |X| >= |Y|) ----------------
    logic [SW-1:0]      sum_n;
    assign sum_n = sub2 ? ({1'b0, xs2} - {1'b0, ys2}) : ({1'b0, xs2} + {1'b0, ys2});

    logic               v3, sp3, s3;
    logic [W-1:0]       spr3;
    logic [3:0]         spf3;
    logic [EXP_W-1:0]   e3;
    logic [SW-1:0]      sum3;

    // ---------------- S4: normalise, round to nearest even, pack ----------------
    logic [CW-1:0]      lz, lsh;
    logic [NW-1:0]      n;
    logic               rnd_up, fcarry;
    logic [MAN_W-1:0]   frac_r;
    int                 ex_n;
    logic [W-1:0]       res_n;
    logic [3:0]         flg_n;

    fp_lzc #(.W(SW), .CW(CW)) u_lzc (
        .din (sum3),
        .cnt (lz)
    );

    always_comb begin
        // lz == 0 means carry-out: shift right one and merge the dropped bit into sticky.
        lsh = (lz == '0) ? '0 : lz - 1'b1;
        n   = (lz == '0) ? {sum3[SW-1:2], |sum3[1:0]} : (sum3[NW-1:0] << lsh);
        rnd_up = n[2] & (n[1] | n[0] | n[3]);
        {fcarry, frac_r} = {1'b0, n[NW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
        ex_n = int'(e3) + 1 - int'(lz) + int'(fcarry);

        res_n = '0;
        flg_n = '0;
        if (sp3) begin
            res_n = spr3;
            flg_n = spf3;
        end else if (!n[NW-1]) begin
            res_n = '0;                           // exact cancellation gives +0
        end else if (ex_n <= 0) begin
            res_n          = s3 ? SIGN : '0;
            flg_n[FLAG_UF] = 1'b1;
            flg_n[FLAG_NX] = 1'b1;
        end else if (ex_n >= EMAX_I) begin
            res_n          = PINF | (s3 ? SIGN : '0);
            flg_n[FLAG_OF] = 1'b1;
            flg_n[FLAG_NX] = 1'b1;
        end else begin
            res_n          = {s3, EXP_W'(ex_n), frac_r};
            flg_n[FLAG_NX] = |n[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            oDone  <= 1'b0;
            oF     <= '0;
            oFlags <= '0;
        end else if (adv) begin
            v1   <= iValid && op_ok;              // no-ops are dropped at the door
            sp1  <= sp_n;
            spr1 <= spr_n;
            spf1 <= spf_n;
            sx1  <= swap ? sb : sa;
            sub1 <= sa ^ sb;
            ex1  <= swap ? eb : ea;
            ey1  <= swap ? ea : eb;
            mx1  <= swap ? mb : ma;
            my1  <= swap ? ma : mb;

            v2   <= v1;
            sp2  <= sp1;
            spr2 <= spr1;
            spf2 <= spf1;
            s2   <= sx1;
            sub2 <= sub1;
            e2   <= ex1;
            xs2  <= {mx1, 3'b000};
            ys2  <= y_al;

            v3   <= v2;
            sp3  <= sp2;
            spr3 <= spr2;
            spf3 <= spf2;
            s3   <= s2;
            e3   <= e2;
            sum3 <= sum_n;

            oDone  <= v3;
            oF     <= res_n;
            oFlags <= flg_n;
        end
    end

endmodule

// File: tb/tb_float_point_addsub_pipe.sv
// tb/tb_float_point_addsub_pipe.sv - directed self-checking bench for float_point_addsub_pipe
module tb_float_point_addsub_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] iA, iB;
    logic [1:0]  iOp;
    logic        iValid;
    logic        oAccept;
    logic        iReady;
    logic [31:0] oF;
    logic        oDone;
    logic [3:0]  oFlags;

    int vectors = 0;
    int misses  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] f;
        logic [3:0]  flg;
    } vec_t;

    float_point_addsub_pipe dut (
        .clk     (clk),
        .reset   (reset),
        .iA      (iA),
        .iB      (iB),
        .iOp     (iOp),
        .iValid  (iValid),
        .oAccept (oAccept),
        .iReady  (iReady),
        .oF      (oF),
        .oDone   (oDone),
        .oFlags  (oFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op from #1 after a rising edge; returns result and the edge count until oDone.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         output logic [31:0] f, output logic [3:0] flg, output int lat);
        iA = a; iB = b; iOp = op; iValid = 1'b1; iReady = 1'b1;
        lat = 0; f = '0; flg = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            iValid = 1'b0;
            if (oDone) begin
                lat = k; f = oF; flg = oFlags;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b1; iValid = 1'b1; iOp = 2'b01; iA = 32'h3F800000; iB = 32'h3F800000; iReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (oDone !== 1'b0)    begin misses++; $display("FAIL reset_oDone got %b want 0", oDone); end
        vectors++; if (oF !== 32'h0)      begin misses++; $display("FAIL reset_oF got %h want 00000000", oF); end
        vectors++; if (oFlags !== 4'h0)   begin misses++; $display("FAIL reset_oFlags got %b want 0000", oFlags); end
        vectors++; if (oAccept !== 1'b1)  begin misses++; $display("FAIL reset_oAccept got %b want 1", oAccept); end
        reset = 1'b0; iValid = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (oDone) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin misses++; $display("FAIL reset_ignore_valid got oDone=1 want none"); end
    endtask

    task automatic test_arith();
        vec_t v[4];
        logic [31:0] f; logic [3:0] flg; int lat;
        v[0] = '{32'h41480000, 32'h41080000, 2'b01, 32'h41A80000, 4'b0000};
        v[1] = '{32'h41480000, 32'h41080000, 2'b10, 32'h40800000, 4'b0000};
        v[2] = '{32'h3F800000, 32'h3F800000, 2'b10, 32'h00000000, 4'b0000};
        v[3] = '{32'hBF800000, 32'h3F000000, 2'b01, 32'hBF000000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, f, flg, lat);
            vectors++; if (lat !== 4)        begin misses++; $display("FAIL arith[%0d] latency got %0d want 4", i, lat); end
            vectors++; if (f !== v[i].f)     begin misses++; $display("FAIL arith[%0d] oF got %h want %h", i, f, v[i].f); end
            vectors++; if (flg !== v[i].flg) begin misses++; $display("FAIL arith[%0d] oFlags got %b want %b", i, flg, v[i].flg); end
        end
    endtask

    task automatic test_rounding();
        vec_t v[4];
        logic [31:0] f; logic [3:0] flg; int lat;
        v[0] = '{32'h3F800000, 32'h33800000, 2'b01, 32'h3F800000, 4'b0001};  // tie, even stays
        v[1] = '{32'h3F800001, 32'h33800000, 2'b01, 32'h3F800002, 4'b0001};  // tie, odd rounds up
        v[2] = '{32'h3F800000, 32'h30800000, 2'b01, 32'h3F800000, 4'b0001};  // shifted fully out
        v[3] = '{32'h00800001, 32'h00800000, 2'b10, 32'h00000000, 4'b0011};  // below min normal
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, f, flg, lat);
            vectors++; if (lat !== 4)        begin misses++; $display("FAIL round[%0d] latency got %0d want 4", i, lat); end
            vectors++; if (f !== v[i].f)     begin misses++; $display("FAIL round[%0d] oF got %h want %h", i, f, v[i].f); end
            vectors++; if (flg !== v[i].flg) begin misses++; $display("FAIL round[%0d] oFlags got %b want %b", i, flg, v[i].flg); end
        end
    endtask

    task automatic test_specials();
        vec_t v[7];
        logic [31:0] f; logic [3:0] flg; int lat;
        v[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 2'b01, 32'h7F800000, 4'b0101};
        v[1] = '{32'h7F800000, 32'h7F800000, 2'b10, 32'h7FC00000, 4'b1000};
        v[2] = '{32'hFF800000, 32'h3F800000, 2'b01, 32'hFF800000, 4'b0000};
        v[3] = '{32'h3F800000, 32'h7F800000, 2'b10, 32'hFF800000, 4'b0000};
        v[4] = '{32'h7FC00001, 32'h3F800000, 2'b01, 32'h7FC00000, 4'b1000};
        v[5] = '{32'h80000000, 32'h80000000, 2'b01, 32'h80000000, 4'b0000};
        v[6] = '{32'h00000000, 32'h80000000, 2'b01, 32'h00000000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            do_op(v[i].a, v[i].b, v[i].op, f, flg, lat);
            vectors++; if (lat !== 4)        begin misses++; $display("FAIL special[%0d] latency got %0d want 4", i, lat); end
            vectors++; if (f !== v[i].f)     begin misses++; $display("FAIL special[%0d] oF got %h want %h", i, f, v[i].f); end
            vectors++; if (flg !== v[i].flg) begin misses++; $display("FAIL special[%0d] oFlags got %b want %b", i, flg, v[i].flg); end
        end
    endtask

    task automatic test_noop();
        logic seen;
        iA = 32'h3F800000; iB = 32'h3F800000; iReady = 1'b1; iValid = 1'b1;
        iOp = 2'b00; @(posedge clk); #1;
        iOp = 2'b11; @(posedge clk); #1;
        iValid = 1'b0;
        seen = 1'b0;
        repeat (8) begin if (oDone) seen = 1'b1; @(posedge clk); #1; end
        vectors++; if (seen !== 1'b0) begin misses++; $display("FAIL noop_dropped got oDone=1 want none"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[8], tb[8], te[8];
        logic [31:0] prev_f;
        logic        prev_stall;
        int sent, rcv, stall_cycles;
        ta[0] = 32'h3F800000; tb[0] = 32'h3F800000; te[0] = 32'h40000000;
        ta[1] = 32'h40000000; tb[1] = 32'h3F800000; te[1] = 32'h40400000;
        ta[2] = 32'h40400000; tb[2] = 32'h3F800000; te[2] = 32'h40800000;
        ta[3] = 32'h3FC00000; tb[3] = 32'h40200000; te[3] = 32'h40800000;
        ta[4] = 32'h41480000; tb[4] = 32'h41080000; te[4] = 32'h41A80000;
        ta[5] = 32'hBF800000; tb[5] = 32'h3F000000; te[5] = 32'hBF000000;
        ta[6] = 32'h00000000; tb[6] = 32'h40A00000; te[6] = 32'h40A00000;
        ta[7] = 32'h42C80000; tb[7] = 32'hC2100000; te[7] = 32'h42800000;
        sent = 0; rcv = 0; stall_cycles = 0; prev_stall = 1'b0; prev_f = '0;
        iOp = 2'b01;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            iValid = (sent < 8);
            if (sent < 8) begin iA = ta[sent]; iB = tb[sent]; end
            iReady = !(cyc >= 3 && cyc <= 9);
            #3;
            vectors++;
            if (oAccept !== !(oDone && !iReady)) begin
                misses++; $display("FAIL bp_accept cyc %0d got %b want %b", cyc, oAccept, !(oDone && !iReady));
            end
            if (oDone && !iReady) stall_cycles++;
            if (prev_stall && oDone) begin
                vectors++;
                if (oF !== prev_f) begin misses++; $display("FAIL bp_hold cyc %0d got %h want %h", cyc, oF, prev_f); end
            end
            if (oDone && iReady) begin
                vectors++;
                if (oF !== te[rcv]) begin misses++; $display("FAIL bp_result[%0d] got %h want %h", rcv, oF, te[rcv]); end
                rcv++;
            end
            prev_stall = oDone && !iReady;
            prev_f     = oF;
            if (iValid && oAccept) sent++;
            @(posedge clk); #1;
        end
        iValid = 1'b0; iReady = 1'b1;
        vectors++; if (rcv !== 8)          begin misses++; $display("FAIL bp_count got %0d want 8", rcv); end
        vectors++; if (stall_cycles !== 6) begin misses++; $display("FAIL bp_stall_cycles got %0d want 6", stall_cycles); end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        logic [31:0] f; logic [3:0] flg; int lat;
        iReady = 1'b1; iValid = 1'b1; iOp = 2'b01;
        iA = 32'h3F800000; iB = 32'h3F800000; @(posedge clk); #1;
        iA = 32'h40000000; iB = 32'h3F800000; @(posedge clk); #1;
        iValid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin if (oDone) seen = 1'b1; @(posedge clk); #1; end
        vectors++; if (seen !== 1'b0) begin misses++; $display("FAIL reset_mid_flushed got oDone=1 want none"); end
        do_op(32'h41480000, 32'h41080000, 2'b01, f, flg, lat);
        vectors++; if (lat !== 4)          begin misses++; $display("FAIL reset_mid_latency got %0d want 4", lat); end
        vectors++; if (f !== 32'h41A80000) begin misses++; $display("FAIL reset_mid_oF got %h want 41a80000", f); end
        vectors++; if (flg !== 4'b0000)    begin misses++; $display("FAIL reset_mid_oFlags got %b want 0000", flg); end
    endtask

    initial begin
        reset = 1'b1; iValid = 1'b0; iA = '0; iB = '0; iOp = 2'b00; iReady = 1'b1;
        test_reset();
        test_arith();
        test_rounding();
        test_specials();
        test_noop();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

endmodule
